mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 2, meaning cycles from request accept edge to resp_valid assertion; legal range 1..15.
REQ-002 Parameter MEM_BYTES, default 256, meaning size of the byte-addressed storage array.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_write  input  1  1 = word store, 0 = word load.
REQ-007 req_addr  input  32  byte address of the word.
REQ-008 req_wdata  input  32  store data.
REQ-009 req_ready  output  1  responder can accept a request this cycle.
REQ-010 resp_valid  output  1  response present.
REQ-011 resp_ready  input  1  initiator consumes the response.
REQ-012 resp_rdata  output  32  load data; zero for stores and errors.
REQ-013 resp_err  output  1  request was misaligned or out of range.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-015 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-016 On accept, the block SHALL go IDLE->WAIT, load the latency counter with LATENCY-1, and capture addr, write flag and wdata.
REQ-017 WAIT SHALL decrement the counter each cycle and go to RESP on the edge where the counter is 0, so resp_valid rises exactly LATENCY cycles after the accept edge.
REQ-018 RESP SHALL hold resp_valid, resp_rdata and resp_err stable until resp_ready=1 is sampled, then go to IDLE.
REQ-019 In RESP, resp_ready=1 and a new req_valid in the same cycle SHALL NOT start the new request, because req_ready is 0 in RESP; the earliest next accept is the following cycle.
REQ-020 A request with req_addr[1:0] != 0 SHALL set resp_err=1 and resp_rdata=0, and SHALL NOT modify storage.
REQ-021 A request with req_addr > MEM_BYTES-4 SHALL set resp_err=1 and resp_rdata=0, and SHALL NOT modify storage.
REQ-022 Only req_addr[31:0] compared against MEM_BYTES SHALL decide range; there is no address wrap-around.
REQ-023 Word layout SHALL be little-endian: byte at addr -> bits 7:0, addr+3 -> bits 31:24.
REQ-024 A legal store SHALL commit all four bytes on the accept edge.
REQ-025 A legal load SHALL read storage on the accept edge, so back-to-back store-then-load to the same address returns the new data.
REQ-026 req_addr, req_write and req_wdata SHALL be ignored outside accept edges.
REQ-027 resp_rdata SHALL be 0 whenever resp_valid=0.

Reset
REQ-028 Reset SHALL force the FSM to IDLE, the counter to 0, req_ready=1, resp_valid=0, resp_rdata=0 and resp_err=0, independent of clk.
REQ-029 Reset during WAIT or RESP SHALL abort the transaction without a response; a store already committed stays committed.
REQ-030 Storage contents SHALL NOT be cleared by reset.
REQ-031 The first accept after reset deassertion SHALL be possible on the first rising edge with reset=0.

Structure
REQ-032 The state encoding (IDLE=2'b00, WAIT=2'b01, RESP=2'b10) and the default MEM_BYTES SHALL live in the shared CPU package.
REQ-033 Storage SHALL be a sub-module mem_byte_array with one 32-bit little-endian read/write word port.
REQ-034 The FSM, counter, capture registers and error check SHALL stay in mem_responder.

Verification
REQ-035 Scenario: reset, then store addr 0x10 data 0xDEADBEEF, LATENCY=2 -> resp_valid rises 2 cycles after accept, resp_err=0, resp_rdata=0.
REQ-036 Scenario: load addr 0x10 right after the previous response -> resp_rdata=0xDEADBEEF; a byte view of addr 0x10 equals 0xEF.
REQ-037 Scenario: load addr 0x12 -> resp_err=1, resp_rdata=0, storage unchanged.
REQ-038 Scenario: store addr 0xFC, then load addr 0xFC -> pass; store addr 0x100 -> resp_err=1 with no write.
REQ-039 Scenario: hold resp_ready=0 for 5 cycles in RESP -> outputs stable and req_ready=0 throughout; resp_ready=1 -> IDLE next cycle.
REQ-040 Scenario: assert reset mid-WAIT of a load -> resp_valid never rises, req_ready=1 immediately, and previously stored data survives.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
// Shared definitions for the memory responder slice: FSM state encoding,
// default storage size, latency counter width and the request address check.
package mem_responder_pkg;

    localparam int unsigned DEFAULT_MEM_BYTES = 256;

    // Wide enough for the largest supported LATENCY-1 (14).
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } respState_t;

    // A word access is rejected when misaligned or when any of its four bytes
    // would fall past the end of storage. The full 32-bit address is compared,
    // so large addresses never alias back into the array.
    function automatic logic isBadAddr(input logic [31:0] addr,
                                       input int unsigned memBytes);
        return (addr[1:0] != 2'b00) || (addr > 32'(memBytes - 4));
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// mem_byte_array
// Byte-addressed storage with a single 32-bit little-endian word port.
// Reads are combinational; writes commit all four bytes on the rising edge.
// Contents have no reset.
//   clk   : clock
//   we    : write enable for the word at addr
//   addr  : byte address of the word (lowest byte)
//   wdata : store data, bits 7:0 go to addr, bits 31:24 to addr+3
//   rdata : word at addr, same byte order; bytes past the end read as zero
module mem_byte_array
    import mem_responder_pkg::*;
#(
    parameter int unsigned MEM_BYTES = DEFAULT_MEM_BYTES,
    parameter int unsigned AW        = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [7:0] mem [MEM_BYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned k = 0; k < 4; k++) begin
                mem[AW'(32'(addr) + k)] <= wdata[8*k +: 8];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (32'(addr) + k < MEM_BYTES) begin
                rdata[8*k +: 8] = mem[AW'(32'(addr) + k)];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder
// Single-outstanding word load/store responder with fixed response latency.
// A request is accepted in IDLE; stores commit and loads read storage on the
// accept edge, the response appears LATENCY cycles later and is held until
// the initiator takes it.
//   clk        : clock, all state on rising edge
//   reset      : asynchronous active-high reset (storage is not cleared)
//   req_valid  : request present
//   req_write  : 1 = store, 0 = load
//   req_addr   : byte address of the word
//   req_wdata  : store data
//   req_ready  : high only in IDLE
//   resp_valid : response present (RESP state)
//   resp_ready : initiator consumes response
//   resp_rdata : load data; zero for stores, errors and when no response
//   resp_err   : misaligned or out-of-range request
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned MEM_BYTES = DEFAULT_MEM_BYTES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned     AW       = $clog2(MEM_BYTES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    respState_t       state, nextState;
    logic [CNT_W-1:0] cnt, nextCnt;
    logic [31:0]      rdataQ;
    logic             errQ;
    logic             accept;
    logic             addrBad;
    logic             memWe;
    logic [31:0]      memRdata;

    assign addrBad = isBadAddr(req_addr, MEM_BYTES);
    assign memWe   = accept && req_write && !addrBad;

    mem_byte_array #(
        .MEM_BYTES (MEM_BYTES),
        .AW        (AW)
    ) uMem (
        .clk   (clk),
        .we    (memWe),
        .addr  (req_addr[AW-1:0]),
        .wdata (req_wdata),
        .rdata (memRdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            rdataQ <= '0;
            errQ   <= 1'b0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
            // Load data is captured here, so a store committed on an earlier
            // edge is always visible to a later load.
            if (accept) begin
                errQ   <= addrBad;
                rdataQ <= (req_write || addrBad) ? '0 : memRdata;
            end
        end
    end

    always_comb begin
        nextState  = state;
        nextCnt    = cnt;
        accept     = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    nextState = WAIT;
                    nextCnt   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    nextState = RESP;
                end else begin
                    nextCnt = cnt - 1'b1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdataQ;
                resp_err   = errQ;
                if (resp_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

endmodule
